dti_rr_mux: RTL and testbench
=============================

Name: dti_rr_mux

Overview:
- Round-robin arbiter that merges NUM_IN dti producer channels into one dti consumer channel.
- Each transfer is tagged with the index of the input it came from.
- Output is registered: one pipeline slot, full throughput.
- Optional packet lock keeps the grant on one input until it sends a transfer whose data MSB is set (eot, queue convention), so multi-beat packets are never interleaved.
- Sits in front of shared sinks: memory write ports, shared DSP units, trace collectors.

Parameters:
- NUM_IN, 4, number of input channels; legal range 2..16.
- W_DATA, 16, data width of each input channel.
- W_SEL, $clog2(NUM_IN), width of the index tag; derived, not overridden.
- LOCK_EOT, 0, when 1 the grant is held across a packet until the eot beat, i.e. din data bit W_DATA-1 = 1.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset (asserted when 0).
- din_data  in  NUM_IN*W_DATA  input data; channel i occupies bits [i*W_DATA +: W_DATA].
- din_valid  in  NUM_IN  per-channel valid.
- din_ready  out  NUM_IN  per-channel ready; one-hot or zero.
- dout_data  out  W_DATA+W_SEL  {index tag, data}; tag in the MSBs.
- dout_valid  out  1  output valid.
- dout_ready  in  1  output ready.

Behaviour:
- Reset (rst==0 at a clk edge): dout_valid=0, dout_data=0, priority pointer ptr=0, state=ARB, din_ready all 0 during reset.
- Output slot:
  - slot_free = !dout_valid || dout_ready.
  - din_ready[i] = slot_free && (i == grant) && din_valid[i]; at most one bit set.
  - On a handshake on input g: dout_data <= {g, din_data[g]}, dout_valid <= 1.
  - Otherwise, if dout_ready: dout_valid <= 0.
  - Latency is 1 cycle; back-to-back transfers sustain 1 transfer per cycle.
- Stall rule: while dout_valid && !dout_ready, dout_valid and dout_data hold stable. This satisfies the hold-valid and stable-data protocol checks.
- dout_ready may combinationally reach din_ready. No path from any din_valid to dout_valid within a cycle.
- Grant (ARB state): grant = first i with din_valid[i]==1, searching ptr, ptr+1, …, NUM_IN-1, 0, …, ptr-1. No valid input means no grant and no din_ready.
- Pointer update: on a handshake from input g, ptr <= (g+1) mod NUM_IN. Wrap uses an explicit compare, not a power-of-2 mask, so non-power-of-2 NUM_IN works.
- LOCK_EOT=1 FSM (states ARB, LOCKED; locked index lk):
  - ARB → LOCKED on a handshake from g with eot=0; lk <= g.
  - In LOCKED, grant = lk only; other inputs get no ready even when valid.
  - LOCKED → ARB on a handshake from lk with eot=1.
  - An ARB handshake with eot=1 stays in ARB (single-beat packet).
- LOCK_EOT=0: the FSM is removed and every beat re-arbitrates.
- Simultaneous events: a new accept and a drain in the same cycle is a legal overwrite of the slot (dout_ready=1 with a handshake); no bubble.
- Reset mid-operation: an in-flight output and any lock are discarded; ptr returns to 0.
- Inputs with X data while valid=0 must not propagate; dout_data only loads on a handshake.

Decomposition:
- Package dti_arb_pkg holds:
  - typedef arb_state_t {ARB, LOCKED};
  - function rr_next(idx, n), giving the wrapping increment.
- One sub-module, rr_arbiter (params NUM_IN):
  - inputs: req[NUM_IN], ptr;
  - output: one-hot gnt plus binary gnt_idx;
  - purely combinational rotate-priority-encode.
- dti_rr_mux owns ptr, the FSM and the output register.
- The bench binds dti_spy on each din channel and on dout.

Test Plan:
- Fairness: NUM_IN=4, LOCK_EOT=0, all din_valid=1 with data 0xA0+i, dout_ready=1 → dout_data tags 0,1,2,3,0,1… one per cycle from cycle 1; data 0xA0..0xA3.
- Sparse requests: only inputs 1 and 3 valid, ptr=2 → first grant 3, then 1, then 3; inputs 0 and 2 never see ready.
- Backpressure: dout_ready=0 for 5 cycles after the first accept (tag 2, data 0x1234) → dout_valid=1 and dout_data={2,0x1234} stable for 5 cycles, all din_ready=0; first cycle with dout_ready=1 accepts the next input with no bubble.
- Packet lock: LOCK_EOT=1, input 0 sends beats 0x0001, 0x0002, 0x8003 (eot) while input 1 is valid → output order tag0×3 then tag1; input 1 never ready during the lock.
- Reset mid-lock: after input 0's first non-eot beat, rst=0 for 1 cycle → dout_valid=0, ptr=0, state ARB; next cycle input 1 alone is valid and is granted.
- NUM_IN=3 wrap: all valid → tags 0,1,2,0; the pointer never reaches 3.

Source files
------------

// File: rtl/dti_arb_pkg.sv
// Shared types and helpers for the dti round-robin merge.
package dti_arb_pkg;

  // Arbitration state: free re-arbitration or held on one input until eot.
  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Wrapping increment by explicit compare so non-power-of-2 counts wrap correctly.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority encoder: first requester at or after ptr wins.
module rr_arbiter #(
  parameter  int NUM_IN = 4,
  localparam int W_SEL  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [W_SEL-1:0]  ptr,
  output logic [NUM_IN-1:0] gnt,
  output logic [W_SEL-1:0]  gnt_idx,
  output logic              gnt_vld
);

  // Walk ptr, ptr+1, ... wrapping at NUM_IN; the first set request takes the grant.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (!gnt_vld && req[idx]) begin
        gnt_vld      = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = W_SEL'(idx);
      end
    end
  end

endmodule

// File: rtl/dti_rr_mux.sv
// Round-robin merge of NUM_IN dti channels into one registered, index-tagged dti output.
module dti_rr_mux
  import dti_arb_pkg::*;
#(
  parameter  int NUM_IN   = 4,
  parameter  int W_DATA   = 16,
  parameter  int LOCK_EOT = 0,
  localparam int W_SEL    = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*W_DATA-1:0] din_data,
  input  logic [NUM_IN-1:0]        din_valid,
  output logic [NUM_IN-1:0]        din_ready,
  output logic [W_DATA+W_SEL-1:0]  dout_data,
  output logic                     dout_valid,
  input  logic                     dout_ready
);

  localparam logic [NUM_IN-1:0] ONE_HOT0 = NUM_IN'(1);

  logic [W_DATA-1:0]        ch_data [NUM_IN];
  logic [W_DATA-1:0]        sel_data;
  logic [W_SEL-1:0]         ptr_reg;
  logic [W_DATA+W_SEL-1:0]  dout_data_reg;
  logic                     dout_valid_reg;
  arb_state_t               state_reg;
  logic [W_SEL-1:0]         lk_reg;
  logic [NUM_IN-1:0]        req;
  logic [NUM_IN-1:0]        gnt;
  logic [W_SEL-1:0]         gnt_idx;
  logic                     gnt_vld;
  logic                     slot_free;
  logic                     hs;

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_ch
    assign ch_data[gi] = din_data[gi*W_DATA +: W_DATA];
  end

  // While locked only the locked input may compete; otherwise every valid input does.
  always_comb begin
    req = din_valid;
    if (state_reg == LOCKED) req = din_valid & (ONE_HOT0 << lk_reg);
  end

  rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
    .req     (req),
    .ptr     (ptr_reg),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // One-hot data mux; only the granted channel's data is ever looked at.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt[i]) sel_data = ch_data[i];
    end
  end

  assign slot_free = !dout_valid_reg || dout_ready;
  assign hs        = rst && slot_free && gnt_vld;
  assign din_ready = hs ? gnt : '0;

  // Output slot and priority pointer; the slot loads only on a handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_valid_reg <= 1'b0;
      dout_data_reg  <= '0;
      ptr_reg        <= '0;
    end else if (hs) begin
      dout_valid_reg <= 1'b1;
      dout_data_reg  <= {gnt_idx, sel_data};
      ptr_reg        <= W_SEL'(rr_next(int'(gnt_idx), NUM_IN));
    end else if (dout_ready) begin
      dout_valid_reg <= 1'b0;
    end
  end

  assign dout_data  = dout_data_reg;
  assign dout_valid = dout_valid_reg;

  if (LOCK_EOT != 0) begin : g_lock
    arb_state_t       state_next;
    logic [W_SEL-1:0] lk_next;
    logic             eot;

    assign eot = sel_data[W_DATA-1];

    // Lock state register.
    always_ff @(posedge clk) begin
      if (!rst) begin
        state_reg <= ARB;
        lk_reg    <= '0;
      end else begin
        state_reg <= state_next;
        lk_reg    <= lk_next;
      end
    end

    // Enter the lock on a non-eot beat, leave it on the locked input's eot beat.
    always_comb begin
      state_next = state_reg;
      lk_next    = lk_reg;
      if (hs) begin
        case (state_reg)
          ARB: begin
            if (!eot) begin
              state_next = LOCKED;
              lk_next    = gnt_idx;
            end
          end
          LOCKED: begin
            if (eot) state_next = ARB;
          end
          default: state_next = ARB;
        endcase
      end
    end
  end else begin : g_nolock
    assign state_reg = ARB;
    assign lk_reg    = '0;
  end

endmodule

// File: tb/tb_dti_rr_mux.sv
// Directed bench for dti_rr_mux: fairness, sparse, backpressure, packet lock, reset, NUM_IN=3 wrap.
module tb_dti_rr_mux;

  logic clk;
  logic rst;

  // a: NUM_IN=4 no lock; b: NUM_IN=4 with lock; c: NUM_IN=3 no lock
  logic [63:0] a_din_data;
  logic [3:0]  a_din_valid, a_din_ready;
  logic [17:0] a_dout_data;
  logic        a_dout_valid, a_dout_ready;

  logic [63:0] b_din_data;
  logic [3:0]  b_din_valid, b_din_ready;
  logic [17:0] b_dout_data;
  logic        b_dout_valid, b_dout_ready;

  logic [47:0] c_din_data;
  logic [2:0]  c_din_valid, c_din_ready;
  logic [17:0] c_dout_data;
  logic        c_dout_valid, c_dout_ready;

  int n_checks;
  int n_errors;

  dti_rr_mux #(.NUM_IN(4), .W_DATA(16), .LOCK_EOT(0)) u_a (
    .clk(clk), .rst(rst), .din_data(a_din_data), .din_valid(a_din_valid),
    .din_ready(a_din_ready), .dout_data(a_dout_data), .dout_valid(a_dout_valid),
    .dout_ready(a_dout_ready)
  );

  dti_rr_mux #(.NUM_IN(4), .W_DATA(16), .LOCK_EOT(1)) u_b (
    .clk(clk), .rst(rst), .din_data(b_din_data), .din_valid(b_din_valid),
    .din_ready(b_din_ready), .dout_data(b_dout_data), .dout_valid(b_dout_valid),
    .dout_ready(b_dout_ready)
  );

  dti_rr_mux #(.NUM_IN(3), .W_DATA(16), .LOCK_EOT(0)) u_c (
    .clk(clk), .rst(rst), .din_data(c_din_data), .din_valid(c_din_valid),
    .din_ready(c_din_ready), .dout_data(c_dout_data), .dout_valid(c_dout_valid),
    .dout_ready(c_dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison; print one line for it.
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, act);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    a_din_data = '0; a_din_valid = '0; a_dout_ready = 1'b0;
    b_din_data = '0; b_din_valid = '0; b_dout_ready = 1'b0;
    c_din_data = '0; c_din_valid = '0; c_dout_ready = 1'b0;

    // ---------------- reset ----------------
    step();
    step();
    a_din_valid = 4'hF;
    #1;
    check("rst_a_valid", 32'(a_dout_valid), 32'd0);
    check("rst_a_data", 32'(a_dout_data), 32'd0);
    check("rst_a_ready", 32'(a_din_ready), 32'd0);
    check("rst_b_valid", 32'(b_dout_valid), 32'd0);
    a_din_valid = '0;
    rst = 1'b1;
    step();

    // ---------------- fairness (a) ----------------
    for (int i = 0; i < 4; i++) a_din_data[i*16 +: 16] = 16'h00A0 + 16'(i);
    a_din_valid  = 4'hF;
    a_dout_ready = 1'b1;
    #1;
    check("fair_ready0", 32'(a_din_ready), 32'h1);
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("fair_data%0d", k), 32'(a_dout_data),
            ((k % 4) << 16) | (32'hA0 + 32'(k % 4)));
      check($sformatf("fair_ready%0d", k + 1), 32'(a_din_ready), 32'(1 << ((k + 1) % 4)));
    end
    check("fair_valid", 32'(a_dout_valid), 32'd1);
    // pointer is now 2

    // ---------------- sparse (a) ----------------
    a_din_valid = 4'b1010;
    #1;
    check("sparse_ready_a", 32'(a_din_ready), 32'b1000);
    step();
    check("sparse_data_a", 32'(a_dout_data), 32'h300A3);
    check("sparse_ready_b", 32'(a_din_ready), 32'b0010);
    step();
    check("sparse_data_b", 32'(a_dout_data), 32'h100A1);
    check("sparse_ready_c", 32'(a_din_ready), 32'b1000);
    step();
    check("sparse_data_c", 32'(a_dout_data), 32'h300A3);
    a_din_valid = '0;
    step();
    check("sparse_drain", 32'(a_dout_valid), 32'd0);
    // pointer is now 0

    // ---------------- backpressure (a) ----------------
    a_din_data[2*16 +: 16] = 16'h1234;
    a_din_valid = 4'b0100;
    step();
    check("bp_first", 32'(a_dout_data), 32'h21234);
    a_dout_ready = 1'b0;
    a_din_valid  = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp_valid%0d", k), 32'(a_dout_valid), 32'd1);
      check($sformatf("bp_data%0d", k), 32'(a_dout_data), 32'h21234);
      check($sformatf("bp_ready%0d", k), 32'(a_din_ready), 32'd0);
      step();
    end
    a_dout_ready = 1'b1;
    #1;
    check("bp_resume_ready", 32'(a_din_ready), 32'b1000);
    step();
    check("bp_resume_data", 32'(a_dout_data), 32'h300A3);
    check("bp_resume_valid", 32'(a_dout_valid), 32'd1);
    a_din_valid = '0;
    step();

    // ---------------- packet lock (b) ----------------
    b_dout_ready = 1'b1;
    b_din_data[0 +: 16]  = 16'h0001;
    b_din_data[16 +: 16] = 16'h8BBB;
    b_din_valid = 4'b0011;
    #1;
    check("lock_ready0", 32'(b_din_ready), 32'b0001);
    step();
    check("lock_data0", 32'(b_dout_data), 32'h00001);
    b_din_data[0 +: 16] = 16'h0002;
    #1;
    check("lock_ready1", 32'(b_din_ready), 32'b0001);
    step();
    check("lock_data1", 32'(b_dout_data), 32'h00002);
    b_din_data[0 +: 16] = 16'h8003;
    #1;
    check("lock_ready2", 32'(b_din_ready), 32'b0001);
    step();
    check("lock_data2", 32'(b_dout_data), 32'h08003);
    b_din_valid = 4'b0010;
    #1;
    check("lock_ready3", 32'(b_din_ready), 32'b0010);
    step();
    check("lock_data3", 32'(b_dout_data), 32'h18BBB);
    b_din_valid = '0;
    step();
    // b pointer is now 2, state ARB

    // ---------------- reset mid-lock (a and b) ----------------
    b_din_data[0 +: 16] = 16'h0011;
    b_din_valid = 4'b0001;
    a_din_valid = 4'b0010;
    #1;
    check("rl_ready_b", 32'(b_din_ready), 32'b0001);
    step();
    check("rl_data_b", 32'(b_dout_data), 32'h00011);
    // b is locked on input 0, a pointer is 2
    rst = 1'b0;
    b_din_valid = 4'b0011;
    a_din_valid = 4'hF;
    #1;
    check("rl_ready_in_rst", 32'(b_din_ready), 32'd0);
    step();
    check("rl_valid_b", 32'(b_dout_valid), 32'd0);
    check("rl_data_zero_b", 32'(b_dout_data), 32'd0);
    check("rl_valid_a", 32'(a_dout_valid), 32'd0);
    rst = 1'b1;
    b_din_data[16 +: 16] = 16'h0022;
    b_din_valid = 4'b0010;
    #1;
    check("rl_ready_after_b", 32'(b_din_ready), 32'b0010);
    check("rl_ptr_zero_a", 32'(a_din_ready), 32'b0001);
    step();
    check("rl_data_after_b", 32'(b_dout_data), 32'h10022);
    a_din_valid = '0;
    b_din_valid = '0;
    step();

    // ---------------- NUM_IN=3 wrap (c) ----------------
    for (int i = 0; i < 3; i++) c_din_data[i*16 +: 16] = 16'h00C0 + 16'(i);
    c_din_valid  = 3'b111;
    c_dout_ready = 1'b1;
    #1;
    check("wrap_ready0", 32'(c_din_ready), 32'b001);
    for (int k = 0; k < 4; k++) begin
      t = k % 3;
      step();
      check($sformatf("wrap_data%0d", k), 32'(c_dout_data), (t << 16) | (32'hC0 + 32'(t)));
      check($sformatf("wrap_ready%0d", k + 1), 32'(c_din_ready), 32'(1 << ((k + 1) % 3)));
    end
    c_din_valid = '0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
